key_count_disp: RTL and testbench

//  - Consumes the one-cycle key-press pulse produced by the key debounce filter.
//  - Keeps a DIGITS-wide decimal (BCD) press count.
//  - Drives a time-multiplexed common-anode 7-segment display from that count.
//  - Sits between the debounce filter and the board's segment/digit pins in the key-count demo.

---
 rtl/key_pkg.sv | 21 ++
 rtl/key_count_disp_if.sv | 14 +
 rtl/seg7_decode.sv | 16 +
 rtl/key_count_disp.sv | 103 ++++++++++
 tb/tb_key_count_disp.sv | 133 +++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared constants for the key-count demo: segment codes, blank pattern,
// board clock rate, and the single-digit BCD increment.
package key_pkg;

  localparam int CLK_HZ = 50_000_000;

  typedef logic [3:0] bcd_t;

  // Active-low {dp,g,f,e,d,c,b,a}; element n is the code for digit n.
  localparam logic [9:0][7:0] SEG_LUT = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/key_count_disp_if.sv
// Press-pulse input and count / display output bundle of key_count_disp.
interface key_count_disp_if #(
  parameter int DIGITS = 4
);
  logic                  flag;
  logic                  clr;
  logic [4*DIGITS-1:0]   count_bcd;
  logic                  ovf;
  logic [DIGITS-1:0]     sel;
  logic [7:0]            seg;

  modport master (output flag, clr, input count_bcd, ovf, sel, seg);
  modport slave  (input flag, clr, output count_bcd, ovf, sel, seg);
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment code; blank or non-BCD
// input gives all segments off.
module seg7_decode
  import key_pkg::*;
(
  input  bcd_t       bcd_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i && (bcd_i <= 4'd9)) seg_o = SEG_LUT[bcd_i];
  end

endmodule

// File: rtl/key_count_disp.sv
// BCD press counter with ripple carry, plus a time-multiplexed common-anode
// 7-segment scanner that registers sel and seg together.
module key_count_disp
  import key_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter bit LZB      = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  key_count_disp_if.slave bus
);

  localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // ---------------- counter ----------------
  bcd_t [DIGITS-1:0] cnt_q, cnt_d, inc_val;
  logic [DIGITS-1:0] is9, is0, zero_hi;
  logic [DIGITS:0]   carry;
  logic              ovf_q, ovf_d;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign is9[i]     = (cnt_q[i] == 4'd9);
    assign is0[i]     = (cnt_q[i] == 4'd0);
    assign inc_val[i] = bcd_inc(cnt_q[i]);
  end

  // carry[i]: digit i steps this cycle; zero_hi[i]: digits i..top all zero
  always_comb begin
    carry   = '0;
    zero_hi = '0;
    carry[0] = bus.flag;
    for (int i = 0; i < DIGITS; i++) carry[i+1] = carry[i] & is9[i];
    zero_hi[DIGITS-1] = is0[DIGITS-1];
    for (int i = DIGITS - 2; i >= 0; i--) zero_hi[i] = zero_hi[i+1] & is0[i];
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (bus.clr) begin
      cnt_d = '0;
    end else begin
      for (int i = 0; i < DIGITS; i++)
        if (carry[i]) cnt_d[i] = inc_val[i];
      ovf_d = carry[DIGITS];
    end
  end

  // ---------------- scanner ----------------
  logic [DIVW-1:0]   div_q, div_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;
  bcd_t              cur_bcd;
  logic              cur_blank;

  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIVW'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDXW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Units digit is never blanked so a zero count still shows "0".
  assign cur_bcd   = cnt_q[idx_q];
  assign cur_blank = LZB && (idx_q != '0) && zero_hi[idx_q];
  assign sel_d     = ~(DIGITS'(1) << idx_q);

  seg7_decode u_dec (
    .bcd_i   (cur_bcd),
    .blank_i (cur_blank),
    .seg_o   (seg_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      div_q <= '0;
      idx_q <= '0;
      sel_q <= ~DIGITS'(1);
      seg_q <= SEG_LUT[0];
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      div_q <= div_d;
      idx_q <= idx_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign bus.count_bcd = cnt_q;
  assign bus.ovf       = ovf_q;
  assign bus.sel       = sel_q;
  assign bus.seg       = seg_q;

endmodule

// File: tb/tb_key_count_disp.sv
// Directed bench for key_count_disp with DIGITS=4, SCAN_DIV=4, LZB=1.
module tb_key_count_disp;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  key_count_disp_if #(.DIGITS(4)) bus ();

  key_count_disp #(.DIGITS(4), .SCAN_DIV(4), .LZB(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bounded wait for a given digit slot; a timeout shows up as a sel miscompare.
  task automatic wait_sel(input logic [3:0] tgt, input string tag);
    int k = 0;
    while (bus.sel !== tgt && k < 40) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(bus.sel), 32'(tgt));
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.flag = 1'b0;
    bus.clr  = 1'b0;
    #2 rst = 1'b1;
    #1;
    // 1. reset values and scan order
    chk("rst_count", 32'(bus.count_bcd), 32'h0000);
    chk("rst_ovf",   32'(bus.ovf),       32'h0);
    chk("rst_sel",   32'(bus.sel),       32'hE);
    chk("rst_seg",   32'(bus.seg),       32'hC0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(1);  chk("scan_e1",  32'(bus.sel), 32'hE);
    chk("scan_seg0", 32'(bus.seg), 32'hC0);
    tick(3);  chk("scan_e4",  32'(bus.sel), 32'hE);
    tick(1);  chk("scan_e5",  32'(bus.sel), 32'hD);
    chk("scan_blank1", 32'(bus.seg), 32'hFF);
    tick(4);  chk("scan_e9",  32'(bus.sel), 32'hB);
    tick(4);  chk("scan_e13", 32'(bus.sel), 32'h7);
    tick(4);  chk("scan_e17", 32'(bus.sel), 32'hE);

    // 2. twelve single-cycle pulses
    for (int i = 0; i < 12; i++) begin
      bus.flag = 1'b1; tick(1);
      bus.flag = 1'b0; tick(1);
    end
    chk("cnt12", 32'(bus.count_bcd), 32'h0012);
    chk("cnt12_ovf", 32'(bus.ovf), 32'h0);
    wait_sel(4'b1101, "sel_d1"); chk("seg_d1", 32'(bus.seg), 32'hF9);
    wait_sel(4'b1110, "sel_d0"); chk("seg_d0", 32'(bus.seg), 32'hA4);
    wait_sel(4'b1011, "sel_d2"); chk("seg_d2", 32'(bus.seg), 32'hFF);
    wait_sel(4'b0111, "sel_d3"); chk("seg_d3", 32'(bus.seg), 32'hFF);

    // 3. 0999 -> 1000, no overflow
    do_clr();
    chk("clr_zero", 32'(bus.count_bcd), 32'h0000);
    bus.flag = 1'b1; tick(999); bus.flag = 1'b0;
    chk("cnt999", 32'(bus.count_bcd), 32'h0999);
    bus.flag = 1'b1; tick(1); bus.flag = 1'b0;
    chk("cnt1000", 32'(bus.count_bcd), 32'h1000);
    chk("cnt1000_ovf", 32'(bus.ovf), 32'h0);
    wait_sel(4'b0111, "sel_1000_d3"); chk("seg_1000_d3", 32'(bus.seg), 32'hF9);
    wait_sel(4'b1011, "sel_1000_d2"); chk("seg_1000_d2", 32'(bus.seg), 32'hC0);

    // 4. wrap from 9999
    do_clr();
    bus.flag = 1'b1; tick(9999); bus.flag = 1'b0;
    chk("cnt9999", 32'(bus.count_bcd), 32'h9999);
    chk("cnt9999_ovf", 32'(bus.ovf), 32'h0);
    bus.flag = 1'b1; tick(1); bus.flag = 1'b0;
    chk("wrap_cnt", 32'(bus.count_bcd), 32'h0000);
    chk("wrap_ovf", 32'(bus.ovf), 32'h1);
    tick(1);
    chk("wrap_ovf_drop", 32'(bus.ovf), 32'h0);
    chk("wrap_cnt_hold", 32'(bus.count_bcd), 32'h0000);

    // 5. clr beats flag; held flag counts every cycle
    bus.flag = 1'b1; tick(42); bus.flag = 1'b0;
    chk("cnt42", 32'(bus.count_bcd), 32'h0042);
    bus.clr = 1'b1; bus.flag = 1'b1; tick(1);
    chk("clr_prio", 32'(bus.count_bcd), 32'h0000);
    chk("clr_prio_ovf", 32'(bus.ovf), 32'h0);
    bus.clr = 1'b0; tick(3); bus.flag = 1'b0;
    chk("held3", 32'(bus.count_bcd), 32'h0003);
    wait_sel(4'b1110, "sel_3_d0"); chk("seg_3_d0", 32'(bus.seg), 32'hB0);

    // 6. asynchronous reset while digit 2 is selected
    wait_sel(4'b1011, "sel_pre_rst");
    chk("seg_pre_rst", 32'(bus.seg), 32'hFF);
    #3 rst = 1'b1;
    #1;
    chk("arst_count", 32'(bus.count_bcd), 32'h0000);
    chk("arst_ovf",   32'(bus.ovf),       32'h0);
    chk("arst_sel",   32'(bus.sel),       32'hE);
    chk("arst_seg",   32'(bus.seg),       32'hC0);
    tick(1);
    rst = 1'b0;
    tick(2);
    chk("post_rst_sel", 32'(bus.sel), 32'hE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
